// File: rtl/spi_accel_system.sv
// Accelerometer front end: hardwired sequencer that configures an SPI accelerometer and samples it on INT1.
// Latency: one 24-bit SPI transaction per step; console text follows at one char per clk.
// Backpressure: none; the console cannot stall, and SPI and console activity never overlap.
// Ports: clk/resetn (async active-low); trap (sticky done/fail); out_byte/out_byte_en (console strobe);
//        INT1/INT2 (async accel interrupts); MISO/MOSI/CS/SCLK (SPI mode 0 master).
module spi_accel_system #(
    parameter int CLK_DIV     = 4,
    parameter int NUM_SAMPLES = 4
) (
    input  logic       clk,
    input  logic       resetn,
    output logic       trap,
    output logic [7:0] out_byte,
    output logic       out_byte_en,
    input  logic       INT1,
    input  logic       INT2,
    input  logic       MISO,
    output logic       MOSI,
    output logic       CS,
    output logic       SCLK
);
    localparam int DW = $clog2(2 * CLK_DIV);
    localparam logic [DW-1:0] HALF_M1 = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] GAP_M1  = DW'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {SP_IDLE, SP_LEAD, SP_HIGH, SP_LOW, SP_TRAIL, SP_GAP} spi_st_t;
    typedef enum logic [2:0] {ST_RD_ID, ST_CFG1, ST_CFG2, ST_WAIT, ST_SAMPLE, ST_EMIT, ST_DONE} seq_st_t;

    spi_st_t        spi_st_q, spi_st_d;
    logic [DW-1:0]  div_q, div_d;
    logic [4:0]     bit_q, bit_d;
    logic [23:0]    tx_q, tx_d;
    logic [7:0]     rx_q, rx_d;
    logic           cs_q, cs_d, sclk_q, sclk_d;

    seq_st_t        seq_q, seq_d, ret_q, ret_d;
    logic           launched_q, launched_d;
    logic [23:0]    msg_q, msg_d;
    logic [1:0]     len_q, len_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           trap_q, trap_d;
    logic [7:0]     ob_q, ob_d;
    logic           oben_q, oben_d;
    logic           int1_s1_q, int1_s2_q, int2_s1_q, int2_s2_q, int2_s3_q;

    logic           spi_start, spi_req, spi_done, int2_rise;
    logic [23:0]    spi_word;

    function automatic logic [7:0] hex(input logic [3:0] n);
        hex = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign spi_done  = (spi_st_q == SP_GAP) && (div_q == GAP_M1);
    assign int2_rise = int2_s2_q & ~int2_s3_q;

    // Sequencer
    always_comb begin
        seq_d      = seq_q;
        ret_d      = ret_q;
        launched_d = launched_q;
        msg_d      = msg_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        trap_d     = trap_q;
        ob_d       = ob_q;
        oben_d     = 1'b0;
        spi_req    = 1'b0;
        spi_start  = 1'b0;
        spi_word   = 24'h0;
        case (seq_q)
            ST_RD_ID: begin
                spi_req  = 1'b1;
                spi_word = 24'h0B0000;
                if (spi_done) begin
                    seq_d = ST_EMIT;
                    if (rx_q == 8'hAD) begin
                        msg_d = {8'h4F, 8'h4B, 8'h0A};
                        len_d = 2'd3;
                        ret_d = ST_CFG1;
                    end else begin
                        msg_d = {8'h45, 8'h0A, 8'h00};
                        len_d = 2'd2;
                        ret_d = ST_DONE;
                    end
                end
            end
            ST_CFG1: begin
                spi_req  = 1'b1;
                spi_word = 24'h0A2D02;
                if (spi_done) seq_d = ST_CFG2;
            end
            ST_CFG2: begin
                spi_req  = 1'b1;
                spi_word = 24'h0A2A01;
                if (spi_done) seq_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A pending sample takes priority over a coincident activity edge.
                if (int1_s2_q) begin
                    seq_d = ST_SAMPLE;
                end else if (int2_rise) begin
                    msg_d = {8'h41, 8'h0A, 8'h00};
                    len_d = 2'd2;
                    ret_d = ST_WAIT;
                    seq_d = ST_EMIT;
                end
            end
            ST_SAMPLE: begin
                spi_req  = 1'b1;
                spi_word = 24'h0B0800;
                if (spi_done) begin
                    msg_d = {hex(rx_q[7:4]), hex(rx_q[3:0]), 8'h0A};
                    len_d = 2'd3;
                    cnt_d = cnt_q + 8'd1;
                    ret_d = (cnt_q + 8'd1 == 8'(NUM_SAMPLES)) ? ST_DONE : ST_WAIT;
                    seq_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                ob_d   = msg_q[23:16];
                oben_d = 1'b1;
                msg_d  = {msg_q[15:0], 8'h00};
                len_d  = len_q - 2'd1;
                if (len_q == 2'd1) seq_d = ret_q;
            end
            ST_DONE: trap_d = 1'b1;
            default: seq_d = ST_DONE;
        endcase
        // Launch exactly one transaction per SPI step; cleared when it completes.
        if (spi_req && !launched_q && spi_st_q == SP_IDLE) begin
            spi_start  = 1'b1;
            launched_d = 1'b1;
        end
        if (spi_done) launched_d = 1'b0;
    end

    // SPI master: MOSI is the MSB of the shift register, shifted on each falling SCLK.
    always_comb begin
        spi_st_d = spi_st_q;
        div_d    = div_q + 1'b1;
        bit_d    = bit_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        cs_d     = cs_q;
        sclk_d   = sclk_q;
        case (spi_st_q)
            SP_IDLE: begin
                div_d = '0;
                if (spi_start) begin
                    cs_d     = 1'b0;
                    tx_d     = spi_word;
                    bit_d    = 5'd0;
                    spi_st_d = SP_LEAD;
                end
            end
            SP_LEAD, SP_LOW: begin
                if (div_q == HALF_M1) begin
                    div_d    = '0;
                    sclk_d   = 1'b1;
                    rx_d     = {rx_q[6:0], MISO};
                    spi_st_d = SP_HIGH;
                end
            end
            SP_HIGH: begin
                if (div_q == HALF_M1) begin
                    div_d    = '0;
                    sclk_d   = 1'b0;
                    tx_d     = {tx_q[22:0], 1'b0};
                    bit_d    = bit_q + 5'd1;
                    spi_st_d = (bit_q == 5'd23) ? SP_TRAIL : SP_LOW;
                end
            end
            SP_TRAIL: begin
                if (div_q == HALF_M1) begin
                    div_d    = '0;
                    cs_d     = 1'b1;
                    spi_st_d = SP_GAP;
                end
            end
            SP_GAP: begin
                if (div_q == GAP_M1) begin
                    div_d    = '0;
                    spi_st_d = SP_IDLE;
                end
            end
            default: spi_st_d = SP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            spi_st_q   <= SP_IDLE;
            div_q      <= '0;
            bit_q      <= 5'd0;
            tx_q       <= 24'h0;
            rx_q       <= 8'h0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            seq_q      <= ST_RD_ID;
            ret_q      <= ST_RD_ID;
            launched_q <= 1'b0;
            msg_q      <= 24'h0;
            len_q      <= 2'd0;
            cnt_q      <= 8'd0;
            trap_q     <= 1'b0;
            ob_q       <= 8'h0;
            oben_q     <= 1'b0;
            int1_s1_q  <= 1'b0;
            int1_s2_q  <= 1'b0;
            int2_s1_q  <= 1'b0;
            int2_s2_q  <= 1'b0;
            int2_s3_q  <= 1'b0;
        end else begin
            spi_st_q   <= spi_st_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            seq_q      <= seq_d;
            ret_q      <= ret_d;
            launched_q <= launched_d;
            msg_q      <= msg_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            trap_q     <= trap_d;
            ob_q       <= ob_d;
            oben_q     <= oben_d;
            int1_s1_q  <= INT1;
            int1_s2_q  <= int1_s1_q;
            int2_s1_q  <= INT2;
            int2_s2_q  <= int2_s1_q;
            int2_s3_q  <= int2_s2_q;
        end
    end

    assign trap        = trap_q;
    assign out_byte    = ob_q;
    assign out_byte_en = oben_q;
    assign MOSI        = tx_q[23];
    assign CS          = cs_q;
    assign SCLK        = sclk_q;
endmodule

// File: tb/tb_spi_accel_system.sv
// Bench for spi_accel_system with an ADXL362-like SPI slave model.
// Latency: n/a. Backpressure: n/a.
module tb_spi_accel_system;
    logic       clk, resetn, INT1, INT2, MISO;
    logic       trap, out_byte_en, MOSI, CS, SCLK;
    logic [7:0] out_byte;

    spi_accel_system #(.CLK_DIV(4), .NUM_SAMPLES(4)) dut (
        .clk(clk), .resetn(resetn), .trap(trap), .out_byte(out_byte),
        .out_byte_en(out_byte_en), .INT1(INT1), .INT2(INT2), .MISO(MISO),
        .MOSI(MOSI), .CS(CS), .SCLK(SCLK)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Slave model and bus monitors, all sampled on the falling clk edge.
    logic [7:0]  devid = 8'hAD;
    logic [7:0]  xdata = 8'h00;
    logic [23:0] txq[$];
    logic [7:0]  con[$];
    logic [23:0] sr = 24'h0;
    logic [7:0]  resp = 8'h0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b0, seen_rise = 1'b0;
    int cyc = 0, bitcnt = 0, last_rise = 0, last_fall = 0, cs_fall_t = 0, cs_rise_t = 0;
    int min_per = 1000, max_per = 0, min_lead = 1000, min_trail = 1000, min_gap = 1000;
    int cs_fall_after_trap = 0, en_after_trap = 0;

    always @(negedge clk) begin
        cyc++;
        if (out_byte_en) con.push_back(out_byte);
        if (trap && out_byte_en) en_after_trap++;
        if (CS && !prev_cs) begin
            if (bitcnt == 24) begin
                txq.push_back(sr);
                if (cyc - last_fall < min_trail) min_trail = cyc - last_fall;
            end
            cs_rise_t = cyc;
            seen_rise = 1'b1;
            bitcnt    = 0;
            MISO      = 1'b0;
        end else if (!CS && prev_cs) begin
            if (seen_rise && (cyc - cs_rise_t < min_gap)) min_gap = cyc - cs_rise_t;
            if (trap) cs_fall_after_trap++;
            cs_fall_t = cyc;
            bitcnt    = 0;
            sr        = 24'h0;
            MISO      = 1'b0;
        end
        if (!CS) begin
            if (SCLK && !prev_sclk) begin
                if (bitcnt == 0) begin
                    if (cyc - cs_fall_t < min_lead) min_lead = cyc - cs_fall_t;
                end else begin
                    if (cyc - last_rise < min_per) min_per = cyc - last_rise;
                    if (cyc - last_rise > max_per) max_per = cyc - last_rise;
                end
                last_rise = cyc;
                sr = {sr[22:0], MOSI};
                bitcnt++;
                if (bitcnt == 16)
                    resp = (sr[15:8] != 8'h0B) ? 8'h00 :
                           (sr[7:0] == 8'h00)  ? devid :
                           (sr[7:0] == 8'h08)  ? xdata : 8'h00;
            end else if (!SCLK && prev_sclk) begin
                last_fall = cyc;
                MISO = (bitcnt >= 16 && bitcnt < 24) ? resp[3'(23 - bitcnt)] : 1'b0;
            end
        end
        prev_cs   = CS;
        prev_sclk = SCLK;
    end

    task automatic wait_tx(input int n);
        int budget = 3000;
        while (txq.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (txq.size() < n) begin
            checks++; errors++;
            $display("FAIL wait_tx actual=%0d required=%0d", txq.size(), n);
        end
    endtask

    task automatic wait_con(input int n);
        int budget = 3000;
        while (con.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (con.size() < n) begin
            checks++; errors++;
            $display("FAIL wait_con actual=%0d required=%0d", con.size(), n);
        end
    endtask

    task automatic pulse(input logic which2);
        @(posedge clk); #1;
        if (which2) INT2 = 1'b1; else INT1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        INT1 = 1'b0;
        INT2 = 1'b0;
    endtask

    task automatic check_ok_boot();
        wait_tx(3);
        wait_con(3);
        chk("tx_rd_id", txq[0], 24'h0B0000);
        chk("tx_cfg1",  txq[1], 24'h0A2D02);
        chk("tx_cfg2",  txq[2], 24'h0A2A01);
        chk("ok_len", con.size(), 3);
        chk("ok_c0", con[0], 8'h4F);
        chk("ok_c1", con[1], 8'h4B);
        chk("ok_c2", con[2], 8'h0A);
        repeat (30) @(negedge clk);
    endtask

    typedef struct {
        logic       int2;
        logic [7:0] xd;
        logic [7:0] c0, c1, c2;
        int         len;
        logic       trap_exp;
    } vec_t;
    vec_t tbl[6];

    task automatic apply_row(input int i);
        con.delete();
        txq.delete();
        xdata = tbl[i].xd;
        pulse(tbl[i].int2);
        wait_con(tbl[i].len);
        repeat (20) @(negedge clk);
        chk($sformatf("row%0d_len", i), con.size(), tbl[i].len);
        chk($sformatf("row%0d_c0", i), con[0], tbl[i].c0);
        chk($sformatf("row%0d_c1", i), con[1], tbl[i].c1);
        if (tbl[i].len == 3) chk($sformatf("row%0d_c2", i), con[2], tbl[i].c2);
        chk($sformatf("row%0d_ntx", i), txq.size(), tbl[i].int2 ? 0 : 1);
        if (!tbl[i].int2) chk($sformatf("row%0d_tx", i), txq[0], 24'h0B0800);
        chk($sformatf("row%0d_trap", i), trap, tbl[i].trap_exp);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 8'h3C, 8'h33, 8'h43, 8'h0A, 3, 1'b0};
        tbl[1] = '{1'b1, 8'h00, 8'h41, 8'h0A, 8'h00, 2, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 8'h30, 8'h30, 8'h0A, 3, 1'b0};
        tbl[3] = '{1'b0, 8'h7F, 8'h37, 8'h46, 8'h0A, 3, 1'b0};
        tbl[4] = '{1'b0, 8'h80, 8'h38, 8'h30, 8'h0A, 3, 1'b0};
        tbl[5] = '{1'b0, 8'hFF, 8'h46, 8'h46, 8'h0A, 3, 1'b1};

        resetn = 1'b1; INT1 = 1'b0; INT2 = 1'b0; MISO = 1'b0;
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_trap", trap, 1'b0);
        chk("rst_ob", out_byte, 8'h00);
        chk("rst_en", out_byte_en, 1'b0);
        chk("rst_cs", CS, 1'b1);
        chk("rst_sclk", SCLK, 1'b0);
        chk("rst_mosi", MOSI, 1'b0);

        // Boot with a valid device id, then one sample and an activity message.
        devid = 8'hAD;
        @(posedge clk); #1 resetn = 1'b1;
        check_ok_boot();
        for (int i = 0; i < 2; i++) apply_row(i);

        // Reset in the middle of a sample transaction.
        txq.delete();
        xdata = 8'h55;
        pulse(1'b0);
        begin
            int b = 500;
            while (CS && b > 0) begin @(negedge clk); b--; end
        end
        chk("mid_cs_low", CS, 1'b0);
        repeat (60) @(negedge clk);
        @(posedge clk); #1 resetn = 1'b0;
        #1;
        chk("mid_rst_cs", CS, 1'b1);
        chk("mid_rst_sclk", SCLK, 1'b0);
        chk("mid_rst_trap", trap, 1'b0);
        repeat (20) @(negedge clk);
        chk("mid_rst_notx", txq.size(), 0);
        txq.delete();
        con.delete();
        @(posedge clk); #1 resetn = 1'b1;
        check_ok_boot();
        for (int i = 2; i < 6; i++) apply_row(i);

        // Trap is sticky with no further console or SPI activity.
        con.delete();
        repeat (300) @(negedge clk);
        chk("done_trap", trap, 1'b1);
        chk("done_con", con.size(), 0);
        chk("done_cs_fall", cs_fall_after_trap, 0);
        chk("done_cs", CS, 1'b1);

        // Wrong device id.
        @(posedge clk); #1 resetn = 1'b0;
        repeat (20) @(negedge clk);
        devid = 8'h12;
        txq.delete();
        con.delete();
        cs_fall_after_trap = 0;
        @(posedge clk); #1 resetn = 1'b1;
        wait_con(2);
        repeat (300) @(negedge clk);
        chk("bad_len", con.size(), 2);
        chk("bad_c0", con[0], 8'h45);
        chk("bad_c1", con[1], 8'h0A);
        chk("bad_ntx", txq.size(), 1);
        chk("bad_tx", txq[0], 24'h0B0000);
        chk("bad_trap", trap, 1'b1);
        chk("bad_cs_fall", cs_fall_after_trap, 0);

        // Bus timing collected over the whole run.
        chk("sclk_per_min", min_per, 8);
        chk("sclk_per_max", max_per, 8);
        chk("cs_lead", min_lead >= 4, 1'b1);
        chk("cs_trail", min_trail >= 4, 1'b1);
        chk("cs_gap", min_gap >= 8, 1'b1);
        chk("en_after_trap", en_after_trap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
